spi_rx_fifo: RTL and testbench

SPI_RX_FIFO -- requirements
Module: spi_rx_fifo

---
 rtl/spi_rx_fifo.sv | 149 ++++++++++++++
 tb/tb_spi_rx_fifo.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_rx_fifo.sv
// SPI receive-only front end: synchronises SCLK/CS_N/MISO into clk, deserialises
// words and queues them in a show-ahead FIFO with sticky overflow and frame-abort reporting.
module spi_rx_fifo #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 4,
    parameter int CPOL      = 0,
    parameter int CPHA      = 0,
    parameter int LSB_FIRST = 0
) (
    input  logic                         clk,
    input  logic                         clr_n,
    input  logic                         sclk,
    input  logic                         cs_n,
    input  logic                         miso,
    input  logic                         re,
    input  logic                         ready,
    input  logic                         ovf_clr,
    output logic [DATA_W-1:0]            data,
    output logic                         valid,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [$clog2(DATA_W+1)-1:0]  bit_cnt,
    output logic                         overflow,
    output logic                         frame_err
);

    localparam int   CNT_W       = $clog2(DEPTH + 1);
    localparam int   BIT_W       = $clog2(DATA_W + 1);
    localparam int   PTR_W       = $clog2(DEPTH);
    localparam logic SCLK_IDLE   = (CPOL != 0);
    localparam bit   RISE_SAMPLE = (((CPOL ^ CPHA) & 1) == 0);

    logic sclk_s1, sclk_s2, sclk_s3;
    logic cs_s1, cs_s2, cs_s3;
    logic miso_s1, miso_s2;

    // Third CS_N stage exists only to find the deassertion edge that aborts a frame.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            sclk_s1 <= SCLK_IDLE;
            sclk_s2 <= SCLK_IDLE;
            sclk_s3 <= SCLK_IDLE;
            cs_s1   <= 1'b1;
            cs_s2   <= 1'b1;
            cs_s3   <= 1'b1;
            miso_s1 <= 1'b0;
            miso_s2 <= 1'b0;
        end else begin
            sclk_s1 <= sclk;
            sclk_s2 <= sclk_s1;
            sclk_s3 <= sclk_s2;
            cs_s1   <= cs_n;
            cs_s2   <= cs_s1;
            cs_s3   <= cs_s2;
            miso_s1 <= miso;
            miso_s2 <= miso_s1;
        end
    end

    logic sclk_rise, sclk_fall, sample_edge, sample_evt, cs_rise, last_bit, push;
    logic [DATA_W-1:0] shreg, shift_next;

    assign sclk_rise   = sclk_s2 & ~sclk_s3;
    assign sclk_fall   = ~sclk_s2 & sclk_s3;
    assign sample_edge = RISE_SAMPLE ? sclk_rise : sclk_fall;
    assign sample_evt  = sample_edge & ~cs_s2 & re;
    assign cs_rise     = cs_s2 & ~cs_s3;
    assign last_bit    = (bit_cnt == BIT_W'(DATA_W - 1));
    assign push        = sample_evt & last_bit;

    always_comb begin
        shift_next = shreg;
        if (LSB_FIRST != 0)
            shift_next = {miso_s2, shreg[DATA_W-1:1]};
        else
            shift_next = {shreg[DATA_W-2:0], miso_s2};
    end

    // Sample events and CS_N deassertion are mutually exclusive (opposite CS_N levels).
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            shreg     <= '0;
            bit_cnt   <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            if (cs_rise) begin
                frame_err <= (bit_cnt != '0);
                bit_cnt   <= '0;
                shreg     <= '0;
            end else if (sample_evt) begin
                if (last_bit) begin
                    bit_cnt <= '0;
                    shreg   <= '0;
                end else begin
                    bit_cnt <= bit_cnt + BIT_W'(1);
                    shreg   <= shift_next;
                end
            end
        end
    end

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic              pop, push_ok, drop;

    assign valid   = (count != '0);
    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign pop     = valid & ready;
    assign push_ok = push & (~full | pop);
    assign drop    = push & full & ~pop;
    assign data    = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= shift_next;
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!clr_n)
            overflow <= 1'b0;
        else if (drop)
            overflow <= 1'b1;
        else if (ovf_clr)
            overflow <= 1'b0;
    end

endmodule

// File: tb/tb_spi_rx_fifo.sv
// Bench for spi_rx_fifo: a mode-0 MSB-first instance driven through a word scoreboard,
// plus a mode-3 LSB-first instance for bit-order and sample-edge coverage.
module tb_spi_rx_fifo;

    localparam int DEPTH = 4;

    logic       clk, clr_n, sclk, cs_n, miso, re, ready, ovf_clr;
    logic [7:0] data;
    logic       valid, full, empty, overflow, frame_err;
    logic [2:0] count;
    logic [3:0] bit_cnt;

    logic       sclk3, cs3_n, miso3, ready3;
    logic [7:0] data3;
    logic       valid3, full3, empty3, overflow3, frame_err3;
    logic [2:0] count3;
    logic [3:0] bit_cnt3;

    int         checks = 0;
    int         failures = 0;
    logic [7:0] exp_q[$];
    bit         ovf_exp = 1'b0;
    int         pulses;

    spi_rx_fifo #(.DATA_W(8), .DEPTH(DEPTH), .CPOL(0), .CPHA(0), .LSB_FIRST(0)) u_dut (
        .clk(clk), .clr_n(clr_n), .sclk(sclk), .cs_n(cs_n), .miso(miso), .re(re),
        .ready(ready), .ovf_clr(ovf_clr), .data(data), .valid(valid), .full(full),
        .empty(empty), .count(count), .bit_cnt(bit_cnt), .overflow(overflow),
        .frame_err(frame_err)
    );

    spi_rx_fifo #(.DATA_W(8), .DEPTH(DEPTH), .CPOL(1), .CPHA(1), .LSB_FIRST(1)) u_dut_m3 (
        .clk(clk), .clr_n(clr_n), .sclk(sclk3), .cs_n(cs3_n), .miso(miso3), .re(re),
        .ready(ready3), .ovf_clr(ovf_clr), .data(data3), .valid(valid3), .full(full3),
        .empty(empty3), .count(count3), .bit_cnt(bit_cnt3), .overflow(overflow3),
        .frame_err(frame_err3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Mode 0: MISO set while SCLK low, sampled on the rising edge. With pop_at_push the
    // consumer accepts exactly on the clk edge where the last bit lands (3rd posedge).
    task automatic send_bit(input logic b, input bit pop_at_push);
        miso = b;
        repeat (4) @(negedge clk);
        sclk = 1'b1;
        repeat (2) @(negedge clk);
        if (pop_at_push) begin
            chk("pop_at_push_data", data, exp_q.size() > 0 ? exp_q[0] : 8'h00);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            ready = 1'b1;
        end
        @(negedge clk);
        ready = 1'b0;
        @(negedge clk);
        sclk = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit pop_at_push);
        for (int i = 7; i >= 0; i--)
            send_bit(b[i], (i == 0) && pop_at_push);
        if (exp_q.size() < DEPTH)
            exp_q.push_back(b);
        else
            ovf_exp = 1'b1;
    endtask

    task automatic frame_start();
        cs_n = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic frame_end();
        repeat (2) @(negedge clk);
        cs_n = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic pop_chk(input string tag);
        @(negedge clk);
        chk({tag, "_valid"}, valid, 1'b1);
        chk(tag, data, exp_q.size() > 0 ? exp_q.pop_front() : 8'h00);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
    endtask

    task automatic count_ferr(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (frame_err) n++;
        end
    endtask

    task automatic send3_bit(input logic b);
        sclk3 = 1'b0;
        miso3 = b;
        repeat (4) @(negedge clk);
        sclk3 = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        clr_n = 1'b0; sclk = 1'b0; cs_n = 1'b1; miso = 1'b0; re = 1'b1;
        ready = 1'b0; ovf_clr = 1'b0;
        sclk3 = 1'b1; cs3_n = 1'b1; miso3 = 1'b0; ready3 = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_count", count, 3'd0);
        chk("rst_empty", empty, 1'b1);
        chk("rst_valid", valid, 1'b0);
        chk("rst_full", full, 1'b0);
        chk("rst_data", data, 8'h00);
        chk("rst_bit_cnt", bit_cnt, 4'd0);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_frame_err", frame_err, 1'b0);
        clr_n = 1'b1;
        repeat (4) @(negedge clk);

        // Single word, consumer stalled
        frame_start();
        send_byte(8'hA5, 1'b0);
        frame_end();
        chk("a5_count", count, 3'd1);
        chk("a5_empty", empty, 1'b0);
        pop_chk("a5_data");
        @(negedge clk);
        chk("a5_drained", empty, 1'b1);

        // Five words into a four-deep FIFO
        frame_start();
        for (int i = 1; i <= 5; i++)
            send_byte(8'(8'h11 * i), 1'b0);
        frame_end();
        chk("ovf_full", full, 1'b1);
        chk("ovf_count", count, 3'd4);
        chk("ovf_flag", overflow, ovf_exp);
        for (int i = 0; i < 4; i++)
            pop_chk("ovf_pop");
        @(negedge clk);
        chk("ovf_empty", empty, 1'b1);
        chk("ovf_sticky", overflow, 1'b1);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        ovf_exp = 1'b0;
        @(negedge clk);
        chk("ovf_cleared", overflow, ovf_exp);

        // Push into a full FIFO with a simultaneous pop
        frame_start();
        for (int i = 1; i <= 4; i++)
            send_byte(8'(8'h11 * i), 1'b0);
        chk("pp_full_before", full, 1'b1);
        send_byte(8'h55, 1'b1);
        frame_end();
        chk("pp_count", count, 3'd4);
        chk("pp_no_ovf", overflow, 1'b0);
        for (int i = 0; i < 4; i++)
            pop_chk("pp_pop");
        @(negedge clk);
        chk("pp_empty", empty, 1'b1);

        // Aborted partial word, then a clean word
        frame_start();
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        chk("abort_bits", bit_cnt, 4'd3);
        cs_n = 1'b1;
        count_ferr(8, pulses);
        chk("abort_pulses", pulses, 1);
        chk("abort_bit_cnt", bit_cnt, 4'd0);
        chk("abort_no_word", valid, 1'b0);
        frame_start();
        send_byte(8'h3C, 1'b0);
        frame_end();
        chk("after_abort_count", count, 3'd1);
        pop_chk("after_abort_data");

        // Receive disabled: bits ignored, frame end on zero bits is silent
        frame_start();
        re = 1'b0;
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        chk("re_off_bit_cnt", bit_cnt, 4'd0);
        re = 1'b1;
        cs_n = 1'b1;
        count_ferr(8, pulses);
        chk("re_off_no_ferr", pulses, 0);
        frame_start();
        send_byte(8'h5A, 1'b0);
        frame_end();
        pop_chk("re_on_data");

        // Reset mid-word with data queued and overflow set
        frame_start();
        for (int i = 1; i <= 5; i++)
            send_byte(8'(i), 1'b0);
        pop_chk("mid_pop");
        pop_chk("mid_pop");
        for (int i = 0; i < 5; i++)
            send_bit(1'b1, 1'b0);
        chk("mid_bit_cnt", bit_cnt, 4'd5);
        chk("mid_count", count, 3'd2);
        chk("mid_ovf", overflow, 1'b1);
        clr_n = 1'b0;
        @(negedge clk);
        clr_n = 1'b1;
        exp_q.delete();
        ovf_exp = 1'b0;
        chk("clr_count", count, 3'd0);
        chk("clr_empty", empty, 1'b1);
        chk("clr_bit_cnt", bit_cnt, 4'd0);
        chk("clr_ovf", overflow, ovf_exp);
        chk("clr_data", data, 8'h00);
        repeat (4) @(negedge clk);
        cs_n = 1'b1;
        count_ferr(8, pulses);
        chk("clr_no_ferr", pulses, 0);

        // Mode 3, LSB first: first bit received lands in bit 0
        cs3_n = 1'b0;
        repeat (4) @(negedge clk);
        send3_bit(1'b1);
        for (int i = 0; i < 7; i++)
            send3_bit(1'b0);
        repeat (4) @(negedge clk);
        cs3_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("m3_valid", valid3, 1'b1);
        chk("m3_data", data3, 8'h01);
        chk("m3_no_ferr", frame_err3, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
